ysyx_25030077_ifu: RTL
======================

// Module: ysyx_25030077_ifu
// PURPOSE
//  Instruction fetch unit; the stage directly upstream of the decode/regfile top.
//  Holds the PC and issues single-word fetches to instruction memory over a valid/ready request channel.
//  Returns each fetched instruction with its PC to decode over a valid/ready handshake.
//  Accepts a redirect from execute (branch/jump target).
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC value loaded on reset
// PORTS
//  clk             in   1   sole clock; all state updates on its rising edge
//  reset           in   1   synchronous, active-low reset (sampled on clk rising edge)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  fetch address, always word aligned
//  imem_rsp_valid  in   1   response data valid; exactly one response per accepted request
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  inst_valid      out  1   instruction to decode valid
//  inst_ready      in   1   decode consumes instruction
//  inst            out  32  instruction word
//  inst_pc         out  32  PC of inst
// BEHAVIOUR
//  - Reset (reset==0 at edge): pc=RESET_PC, state=REQ, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, drop=0.
//  - FSM states:
//    - REQ: req_valid=1, addr=pc.
//      - req_ready -> WAIT.
//      - req_valid is held with addr stable until accepted.
//    - WAIT: on rsp_valid: inst<=data, inst_pc<=pc, inst_valid<=1 -> HOLD.
//    - HOLD: inst_valid=1 and inst/inst_pc stable.
//      - On inst_valid&&inst_ready: pc<=pc+4, inst_valid<=0 -> REQ.
//  - Timing: first req_valid appears the cycle after reset releases.
//    - Zero-wait memory: rsp to inst_valid is 1 cycle.
//    - Throughput without prefetch: 1 inst per 3 cycles.
//  - At most one outstanding memory request.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  - Redirect has priority over every other event in the same cycle:
//    - pc<=redirect_pc&~3; inst_valid<=0 (pending inst discarded, even if inst_ready=1 that cycle).
//    - If in WAIT, or a request is accepted that same cycle: set drop.
//      - The next rsp_valid is discarded; drop then clears.
//      - State then returns to REQ.
//    - Otherwise -> REQ next cycle.
//  - rsp_valid simultaneous with redirect in WAIT: response discarded, no drop set.
//  - rsp_valid outside WAIT with drop==0 is ignored.
//  - Reset mid-transaction: state cleared as above. The memory side completes or abandons independently; a late rsp is ignored because state=REQ.
// CONFIGURATION
//  YSYX_IFU_PREFETCH_EN defined:
//    - Adds a one-entry prefetch buffer (data, pc, valid).
//    - While in HOLD with buffer empty, the next request (pc+4) is issued; its response fills the buffer.
//    - On decode handshake with buffer full: buffer moves to inst/inst_pc same edge, inst_valid stays 1.
//    - Throughput 1 inst/cycle with zero-wait memory.
//    - Redirect flushes the buffer and drops any outstanding response.
//  Not defined: no buffer; behaviour exactly as above.
// TESTING
//  - Reset release, req_ready=1, 1-cycle rsp 32'h00000013 -> addr 8000_0000; inst=0x13, inst_pc=8000_0000; next addr 8000_0004.
//  - inst_ready=0 for 5 cycles -> inst_valid held, inst/inst_pc unchanged, no new request (non-prefetch build).
//  - Redirect to 32'h8000_0103 while in WAIT -> next addr 8000_0100; in-flight rsp discarded, never on inst.
//  - pc=FFFF_FFFC accepted -> next addr 0000_0000.
//  - Redirect and inst handshake in same cycle -> inst_valid=0 next cycle; pc=redirect target.
//  - PREFETCH_EN, inst_ready=1 constantly, zero-wait memory -> one inst per cycle, PCs strictly +4, no duplicates or gaps.

Source files
------------

// File: rtl/ysyx_25030077_ifu.sv
// ysyx_25030077_ifu: instruction fetch unit (PC, imem request/response, decode handshake, redirect).
// Optional macro YSYX_IFU_PREFETCH_EN adds a one-entry prefetch buffer for 1 inst/cycle fetch.
`default_nettype none

module ysyx_25030077_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [31:0] pc_q;
  logic        drop_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & ~32'd3;
  assign imem_req_addr   = pc_q;
  assign inst_valid      = inst_valid_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;

`ifdef YSYX_IFU_PREFETCH_EN
  logic        req_en_q;
  logic        pend_q;
  logic [31:0] pend_pc_q;
  logic        pf_valid_q;
  logic [31:0] pf_data_q;
  logic [31:0] pf_pc_q;
  logic        dec_fire;
  logic        req_fire;
  logic        rsp_take;
  logic [1:0]  occ_d;

  // Slots reserved after this edge: held inst, buffer and the outstanding request.
  assign dec_fire = inst_valid_q && inst_ready;
  assign occ_d    = {1'b0, inst_valid_q} + {1'b0, pf_valid_q} + {1'b0, pend_q} - {1'b0, dec_fire};
  assign imem_req_valid = req_en_q && !redirect_valid && !(pend_q && !imem_rsp_valid) &&
                          (occ_d < 2'd2);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = pend_q && imem_rsp_valid && !drop_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_en_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_pc_q    <= 32'd0;
      pf_valid_q   <= 1'b0;
      pf_data_q    <= 32'd0;
      pf_pc_q      <= 32'd0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
    end else begin
      req_en_q <= 1'b1;
      pend_q   <= req_fire || (pend_q && !imem_rsp_valid);
      if (req_fire) begin
        pend_pc_q <= pc_q;
        pc_q      <= pc_q + 32'd4;
      end
      if (redirect_valid) begin
        pc_q         <= redirect_target;
        inst_valid_q <= 1'b0;
        pf_valid_q   <= 1'b0;
        drop_q       <= pend_q && !imem_rsp_valid;
      end else begin
        if (imem_rsp_valid) drop_q <= 1'b0;
        if (dec_fire) begin
          if (pf_valid_q) begin
            inst_q    <= pf_data_q;
            inst_pc_q <= pf_pc_q;
            if (rsp_take) begin
              pf_data_q <= imem_rsp_data;
              pf_pc_q   <= pend_pc_q;
            end else begin
              pf_valid_q <= 1'b0;
            end
          end else if (rsp_take) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pend_pc_q;
          end else begin
            inst_valid_q <= 1'b0;
          end
        end else if (rsp_take) begin
          if (!inst_valid_q) begin
            inst_q       <= imem_rsp_data;
            inst_pc_q    <= pend_pc_q;
            inst_valid_q <= 1'b1;
          end else begin
            pf_data_q  <= imem_rsp_data;
            pf_pc_q    <= pend_pc_q;
            pf_valid_q <= 1'b1;
          end
        end
      end
    end
  end
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state_q;
  logic   req_valid_q;
  logic   req_fire;
  logic   drop_d;

  assign imem_req_valid = req_valid_q;
  assign req_fire       = req_valid_q && imem_req_ready;
  // A response is still owed if we were waiting, just got accepted, or already owed one.
  assign drop_d = ((state_q == S_WAIT) && !imem_rsp_valid) || req_fire ||
                  (drop_q && !imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
    end else if (redirect_valid) begin
      state_q      <= S_REQ;
      pc_q         <= redirect_target;
      inst_valid_q <= 1'b0;
      drop_q       <= drop_d;
      req_valid_q  <= !drop_d;
    end else begin
      case (state_q)
        S_REQ: begin
          // New requests stay blocked until the abandoned response has drained.
          if (drop_q) begin
            if (imem_rsp_valid) begin
              drop_q      <= 1'b0;
              req_valid_q <= 1'b1;
            end
          end else if (req_fire) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q       <= imem_rsp_data;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_q         <= pc_q + 32'd4;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        default: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

`default_nettype wire
